// File: rtl/thermal_pkg.sv
// Shared types, default geometry and the iron colour ramp for the thermal pixel source.
package thermal_pkg;

  localparam int SRC_W = 32;
  localparam int SRC_H = 24;
  localparam int SCALE = 20;

  typedef logic [2:0][7:0] rgb_t;   // [2]=R, [1]=G, [0]=B
  typedef logic [7:0]      temp_idx_t;

  typedef enum logic {
    WR_FILL,   // accepting camera beats into the back buffer
    WR_HOLD    // complete frame waiting for the next vsync to swap
  } wr_state_e;

  // Three linear segments: black->red, red->yellow, yellow->white.
  // Every channel is non-decreasing, so luminance is monotonic.
  function automatic rgb_t iron_palette(temp_idx_t idx);
    rgb_t c;
    c = '0;
    c[2] = (idx < 8'd85) ? idx * 8'd3 : 8'hFF;
    if (idx >= 8'd170)     c[1] = 8'hFF;
    else if (idx >= 8'd85) c[1] = (idx - 8'd85) * 8'd3;
    if (idx >= 8'd170)     c[0] = (idx - 8'd170) * 8'd3;
    return c;
  endfunction

endpackage

// File: rtl/thermal_palette.sv
// Registered 256-entry colour ROM: one cycle from temperature index to RGB.
module thermal_palette
  import thermal_pkg::*;
(
  input  logic            i_clk,
  input  logic [7:0]      i_idx,
  output logic [2:0][7:0] o_rgb
);

  always_ff @(posedge i_clk) begin
    o_rgb <= iron_palette(i_idx);
  end

endmodule

// File: rtl/thermal_frame_source.sv
// Nearest-neighbour upscaler of a double-buffered thermal frame onto VGA timing,
// with a 3-cycle read pipeline and a valid/ready camera write port.
module thermal_frame_source
  import thermal_pkg::*;
#(
  parameter int          P_SRC_W      = SRC_W,
  parameter int          P_SRC_H      = SRC_H,
  parameter int          P_SCALE      = SCALE,
  parameter int          P_H_ACTIVE   = 640,
  parameter int          P_V_ACTIVE   = 480,
  parameter logic        P_VSYNC_ACT  = 1'b0,
  parameter logic [23:0] P_BORDER_RGB = 24'h000000
) (
  input  logic            i_clk_pixel,
  input  logic            i_rst_n,
  input  logic            i_hsync,
  input  logic            i_vsync,
  input  logic            i_blank,
  input  logic [9:0]      i_x_pos,
  input  logic [9:0]      i_y_pos,
  input  logic            i_wr_valid,
  output logic            o_wr_ready,
  input  logic [7:0]      i_wr_data,
  input  logic            i_wr_last,
  output logic            o_wr_err,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic            o_blank,
  output logic [2:0][7:0] o_data
);

  localparam int DEPTH = P_SRC_W * P_SRC_H;
  localparam int AW    = $clog2(DEPTH + 1);   // must also hold DEPTH (full marker)
  localparam int MAW   = $clog2(2 * DEPTH);
  localparam int IMG_W_I = (P_SRC_W * P_SCALE < P_H_ACTIVE) ? P_SRC_W * P_SCALE : P_H_ACTIVE;
  localparam int IMG_H_I = (P_SRC_H * P_SCALE < P_V_ACTIVE) ? P_SRC_H * P_SCALE : P_V_ACTIVE;
  localparam logic [9:0]    IMG_W   = 10'(IMG_W_I);
  localparam logic [9:0]    IMG_H   = 10'(IMG_H_I);
  localparam logic [9:0]    SCALE_L = 10'(P_SCALE);
  localparam logic [9:0]    SRC_W_L = 10'(P_SRC_W);
  localparam logic [AW-1:0] DEPTH_L = AW'(DEPTH);
  localparam logic          INACT   = ~P_VSYNC_ACT;
  localparam logic [2:0]    TIM_RST = {INACT, INACT, 1'b1};

  wr_state_e     wr_state_q, wr_state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          err_q, err_d;
  logic          front_q, front_d;
  logic          fv_q, fv_d;
  logic          accept, mem_we, vs_edge;

  logic [9:0]    sx, sy;
  logic          in_img;
  logic [AW-1:0] rd_addr;
  logic [2:0]    tim0_q, tim1_q, tim2_q;   // {hsync, vsync, blank}
  logic [AW-1:0] addr0_q;
  logic          bank0_q, show0_q, show1_q, show2_q;
  logic [MAW-1:0] wr_idx, rd_idx;
  logic [7:0]    rd_q;
  logic [2:0][7:0] pal_rgb;
  logic [7:0]    mem [2*DEPTH];

  // Write / swap control
  always_comb begin
    wr_state_d = wr_state_q;
    wr_addr_d  = wr_addr_q;
    err_d      = err_q;
    front_d    = front_q;
    fv_d       = fv_q;
    accept     = i_wr_valid && (wr_state_q == WR_FILL);
    mem_we     = accept && (wr_addr_q != DEPTH_L);
    vs_edge    = (i_vsync == P_VSYNC_ACT) && (tim0_q[1] != P_VSYNC_ACT);
    case (wr_state_q)
      WR_FILL: begin
        if (accept) begin
          if (wr_addr_q == DEPTH_L) err_d = 1'b1;
          else                      wr_addr_d = wr_addr_q + AW'(1);
          if (i_wr_last) begin
            wr_addr_d  = '0;
            wr_state_d = WR_HOLD;
          end
        end
      end
      WR_HOLD: begin
        if (vs_edge) begin
          front_d    = ~front_q;
          fv_d       = 1'b1;
          wr_state_d = WR_FILL;
        end
      end
      default: wr_state_d = WR_FILL;
    endcase
  end

  always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_state_q <= WR_FILL;
      wr_addr_q  <= '0;
      err_q      <= 1'b0;
      front_q    <= 1'b0;
      fv_q       <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      err_q      <= err_d;
      front_q    <= front_d;
      fv_q       <= fv_d;
    end
  end

  assign o_wr_ready = (wr_state_q == WR_FILL);
  assign o_wr_err   = err_q;

  // S0 address generation; the bank travels with the pixel it belongs to
  always_comb begin
    sx      = i_x_pos / SCALE_L;
    sy      = i_y_pos / SCALE_L;
    in_img  = (i_x_pos < IMG_W) && (i_y_pos < IMG_H);
    rd_addr = in_img ? AW'(sy * SRC_W_L + sx) : '0;
    wr_idx  = front_q ? MAW'(wr_addr_q) : MAW'(wr_addr_q) + MAW'(DEPTH);
    rd_idx  = bank0_q ? MAW'(addr0_q) + MAW'(DEPTH) : MAW'(addr0_q);
  end

  always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tim0_q  <= TIM_RST;
      tim1_q  <= TIM_RST;
      tim2_q  <= TIM_RST;
      addr0_q <= '0;
      bank0_q <= 1'b0;
      show0_q <= 1'b0;
      show1_q <= 1'b0;
      show2_q <= 1'b0;
    end else begin
      tim0_q  <= {i_hsync, i_vsync, i_blank};
      tim1_q  <= tim0_q;
      tim2_q  <= tim1_q;
      addr0_q <= rd_addr;
      bank0_q <= front_q;
      show0_q <= in_img && fv_q;
      show1_q <= show0_q;
      show2_q <= show1_q;
    end
  end

  always_ff @(posedge i_clk_pixel) begin
    if (mem_we) mem[wr_idx] <= i_wr_data;
    rd_q <= mem[rd_idx];
  end

  thermal_palette u_palette (
    .i_clk (i_clk_pixel),
    .i_idx (rd_q),
    .o_rgb (pal_rgb)
  );

  assign o_hsync = tim2_q[2];
  assign o_vsync = tim2_q[1];
  assign o_blank = tim2_q[0];

  always_comb begin
    o_data = '0;
    if (!tim2_q[0]) o_data = show2_q ? pal_rgb : P_BORDER_RGB;
  end

endmodule

// File: tb/tb_thermal_frame_source.sv
// Scoreboard bench: two instances (scale 20 default border, scale 10 coloured border)
// share all inputs; expected pixels are queued at issue and checked 3 cycles later.
module tb_thermal_frame_source;

  localparam logic [23:0] BRD = 24'h203040;

  logic clk = 1'b0;
  logic rst_n;
  logic hs, vs, bl;
  logic [9:0] x, y;
  logic wr_valid, wr_last;
  logic [7:0] wr_data;
  logic rdy20, rdy10, err20, err10;
  logic hs20, vs20, bl20, hs10, vs10, bl10;
  logic [2:0][7:0] d20, d10;

  thermal_frame_source #(.P_SCALE(20)) dut20 (
    .i_clk_pixel(clk), .i_rst_n(rst_n), .i_hsync(hs), .i_vsync(vs), .i_blank(bl),
    .i_x_pos(x), .i_y_pos(y), .i_wr_valid(wr_valid), .o_wr_ready(rdy20),
    .i_wr_data(wr_data), .i_wr_last(wr_last), .o_wr_err(err20),
    .o_hsync(hs20), .o_vsync(vs20), .o_blank(bl20), .o_data(d20));

  thermal_frame_source #(.P_SCALE(10), .P_BORDER_RGB(BRD)) dut10 (
    .i_clk_pixel(clk), .i_rst_n(rst_n), .i_hsync(hs), .i_vsync(vs), .i_blank(bl),
    .i_x_pos(x), .i_y_pos(y), .i_wr_valid(wr_valid), .o_wr_ready(rdy10),
    .i_wr_data(wr_data), .i_wr_last(wr_last), .o_wr_err(err10),
    .o_hsync(hs10), .o_vsync(vs10), .o_blank(bl10), .o_data(d10));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int unsigned tag;
    logic [2:0]  sync;
    logic [23:0] e20;
    logic [23:0] e10;
  } exp_t;
  exp_t sb[$];

  // Probe points and their expected colours per frame: A(off 0), B(off 100), D(off 50), E(off 7)
  localparam int PX [6] = '{25, 0, 639, 319, 320, 100};
  localparam int PY [6] = '{45, 0, 479, 239, 100, 240};
  localparam logic [23:0] E20 [4][6] = '{
    '{24'hC30000, 24'h000000, 24'hFFFFFF, 24'hFF4E00, 24'hFFFF12, 24'hFF9000},
    '{24'hFFF000, 24'hFF2D00, 24'hFF2A00, 24'hFFFF7B, 24'h3C0000, 24'hFFFFBD},
    '{24'hFF5A00, 24'h960000, 24'h930000, 24'hFFE400, 24'hFFFFA8, 24'hFFFF27},
    '{24'hD80000, 24'h150000, 24'h120000, 24'hFF6300, 24'hFFFF27, 24'hFFA500}};
  localparam logic [23:0] E10 [4][6] = '{
    '{24'hFF8700, 24'h000000, BRD, 24'hFFFFFF, BRD, BRD},
    '{24'hFFFFB4, 24'hFF2D00, BRD, 24'hFF2A00, BRD, BRD},
    '{24'hFFFF1E, 24'h960000, BRD, 24'h930000, BRD, BRD},
    '{24'hFF9C00, 24'h150000, BRD, 24'h120000, BRD, BRD}};

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].tag + 3 <= cyc) begin
      e = sb.pop_front();
      if (e.tag + 3 != cyc) begin
        checks++;
        failures++;
        $display("FAIL sb_timing: got cycle %0d expected %0d", cyc, e.tag + 3);
      end
      cmp("sync20", {29'd0, hs20, vs20, bl20}, {29'd0, e.sync});
      cmp("sync10", {29'd0, hs10, vs10, bl10}, {29'd0, e.sync});
      cmp("rgb20", {8'd0, d20}, {8'd0, e.e20});
      cmp("rgb10", {8'd0, d10}, {8'd0, e.e10});
    end
  end

  task automatic drive(logic h, logic v, logic b, int xx, int yy, bit chk,
                       logic [23:0] e20, logic [23:0] e10);
    exp_t ent;
    @(negedge clk);
    hs = h; vs = v; bl = b; x = 10'(xx); y = 10'(yy);
    if (chk) begin
      ent.tag  = cyc;
      ent.sync = {h, v, b};
      ent.e20  = b ? 24'h0 : e20;
      ent.e10  = b ? 24'h0 : e10;
      sb.push_back(ent);
    end
  endtask

  task automatic show(int f, int reps);
    for (int r = 0; r < reps; r++)
      for (int p = 0; p < 6; p++)
        drive(1'b1, 1'b1, 1'b0, PX[p], PY[p], 1'b1, E20[f][p], E10[f][p]);
  endtask

  task automatic show_border();
    for (int p = 0; p < 6; p++)
      drive(1'b1, 1'b1, 1'b0, PX[p], PY[p], 1'b1, 24'h000000, BRD);
  endtask

  task automatic vsync_pulse();
    repeat (2) drive(1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 24'h0, 24'h0);
    repeat (3) drive(1'b1, 1'b0, 1'b1, 0, 0, 1'b1, 24'h0, 24'h0);
    repeat (2) drive(1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 24'h0, 24'h0);
  endtask

  task automatic status(logic rdy, logic err);
    cmp("ready20", {31'd0, rdy20}, {31'd0, rdy});
    cmp("ready10", {31'd0, rdy10}, {31'd0, rdy});
    cmp("err20", {31'd0, err20}, {31'd0, err});
    cmp("err10", {31'd0, err10}, {31'd0, err});
  endtask

  task automatic reset_checks();
    cmp("rst_sync20", {29'd0, hs20, vs20, bl20}, 32'd7);
    cmp("rst_sync10", {29'd0, hs10, vs10, bl10}, 32'd7);
    cmp("rst_rgb20", {8'd0, d20}, 32'd0);
    cmp("rst_rgb10", {8'd0, d10}, 32'd0);
    status(1'b1, 1'b0);
  endtask

  // Beats at or beyond the buffer depth carry 200 so a wrapped write would be visible.
  task automatic write_beats(int start, int n, int off, bit last_end);
    int i = 0;
    int waited = 0;
    while (i < n) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = (start + i >= 768) ? 8'd200 : 8'((start + i + off) % 256);
      wr_last  = last_end && (i == n - 1);
      if (rdy20) i++;
      else begin
        waited++;
        if (waited > 2000) begin
          checks++;
          failures++;
          $display("FAIL wr_timeout: got %0d beats expected %0d", i, n);
          break;
        end
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    hs = 1'b1; vs = 1'b1; bl = 1'b1; x = '0; y = '0;
    wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
    #1 rst_n = 1'b0;
    #11 reset_checks();
    @(negedge clk);
    rst_n = 1'b1;

    // No frame yet: border in active, zero in blank, timing delayed by 3
    for (int i = 0; i < 8; i++)
      drive(i[0], i[1], i[2], i * 50, i * 30, 1'b1, 24'h000000, BRD);
    show_border();

    // First full frame, swapped on the next vsync
    write_beats(0, 768, 0, 1'b1);
    status(1'b0, 1'b0);
    show_border();
    vsync_pulse();
    status(1'b1, 1'b0);
    show(0, 1);
    drive(1'b1, 1'b1, 1'b1, 25, 45, 1'b1, 24'h0, 24'h0);

    // Frame written during active video must not disturb the displayed one
    fork
      write_beats(0, 768, 100, 1'b1);
      show(0, 130);
    join
    status(1'b0, 1'b0);
    show(0, 1);
    vsync_pulse();
    status(1'b1, 1'b0);
    show(1, 1);

    // Overlong frame: beats past the depth dropped, error sticky, still swapped
    write_beats(0, 768, 50, 1'b0);
    status(1'b1, 1'b0);
    write_beats(768, 1, 50, 1'b0);
    status(1'b1, 1'b1);
    write_beats(769, 31, 50, 1'b1);
    status(1'b0, 1'b1);
    show(1, 1);
    vsync_pulse();
    status(1'b1, 1'b1);
    show(2, 1);

    // Asynchronous reset in the middle of a write and an active line
    drive(1'b1, 1'b1, 1'b0, 25, 45, 1'b0, 24'h0, 24'h0);
    write_beats(0, 300, 90, 1'b0);
    @(posedge clk);
    #2;
    sb.delete();
    rst_n = 1'b0;
    #1 reset_checks();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    show_border();
    status(1'b1, 1'b0);
    write_beats(0, 768, 7, 1'b1);
    vsync_pulse();
    show(3, 1);

    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
